// File: rtl/regfile_sb.sv
// Integer register file with NRD combinational read ports, EX/MEM/WB operand bypass and a
// per-register pending-load scoreboard that raises a stall request for load-use hazards.
module regfile_sb #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned NRD     = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [NRD-1:0]      re_i,
    input  logic [NRD*AW-1:0]   raddr_i,
    output logic [NRD*XLEN-1:0] rdata_o,
    input  logic                ex_we_i,
    input  logic [AW-1:0]       ex_waddr_i,
    input  logic [XLEN-1:0]     ex_wdata_i,
    input  logic                ex_is_load_i,
    input  logic                mem_we_i,
    input  logic [AW-1:0]       mem_waddr_i,
    input  logic [XLEN-1:0]     mem_wdata_i,
    input  logic                mem_is_load_i,
    input  logic                wb_we_i,
    input  logic [AW-1:0]       wb_waddr_i,
    input  logic [XLEN-1:0]     wb_wdata_i,
    input  logic                wb_is_load_i,
    input  logic                iss_load_i,
    input  logic [AW-1:0]       iss_rd_i,
    input  logic                flush_i,
    output logic                stallreq_o
);

    logic [XLEN-1:0]    regs_q [REG_NUM];
    logic [XLEN-1:0]    regs_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    logic [AW-1:0]      rd_addr  [NRD];
    logic [XLEN-1:0]    rd_data  [NRD];
    logic [NRD-1:0]     rd_stall;

    for (genvar k = 0; k < NRD; k++) begin : g_addr
        assign rd_addr[k] = raddr_i[k*AW +: AW];
    end

    // Architectural write from WB; x0 stays zero, rdy low freezes the array.
    always_comb begin
        for (int unsigned i = 0; i < REG_NUM; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (rdy && wb_we_i && (wb_waddr_i != '0)) begin
            regs_d[wb_waddr_i] = wb_wdata_i;
        end
    end

    // Scoreboard: flush clears everything, a returning load clears its bit, a new issue sets one.
    always_comb begin
        busy_d = busy_q;
        if (rdy) begin
            if (flush_i) begin
                busy_d = '0;
            end else begin
                if (wb_we_i && wb_is_load_i) begin
                    busy_d[wb_waddr_i] = 1'b0;
                end
                if (iss_load_i && (iss_rd_i != '0)) begin
                    busy_d[iss_rd_i] = 1'b1;
                end
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Per-port operand select: youngest producer wins, loads still in flight force a stall.
    always_comb begin
        for (int unsigned k = 0; k < NRD; k++) begin
            rd_data[k]  = '0;
            rd_stall[k] = 1'b0;
            if (rst || !re_i[k] || (rd_addr[k] == '0)) begin
                rd_data[k]  = '0;
                rd_stall[k] = 1'b0;
            end else if (ex_we_i && (rd_addr[k] == ex_waddr_i)) begin
                if (ex_is_load_i) begin
                    rd_stall[k] = 1'b1;
                end else begin
                    rd_data[k] = ex_wdata_i;
                end
            end else if (mem_we_i && (rd_addr[k] == mem_waddr_i)) begin
                if (mem_is_load_i) begin
                    rd_stall[k] = 1'b1;
                end else begin
                    rd_data[k] = mem_wdata_i;
                end
            end else if (wb_we_i && (rd_addr[k] == wb_waddr_i)) begin
                rd_data[k] = wb_wdata_i;
            end else if (busy_q[rd_addr[k]]) begin
                rd_stall[k] = 1'b1;
            end else begin
                rd_data[k] = regs_q[rd_addr[k]];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int unsigned k = 0; k < NRD; k++) begin
            rdata_o[k*XLEN +: XLEN] = rd_data[k];
        end
    end

    assign stallreq_o = |rd_stall;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic checked
// against an array-based reference model; a second 3-port 64-bit instance checks wide reads.
module tb_regfile_sb;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rdy;
    logic [1:0]  re;
    logic [9:0]  raddr;
    wire  [63:0] rdata;
    logic        ex_we, ex_is_load, mem_we, mem_is_load, wb_we, wb_is_load, iss_load, flush;
    logic [4:0]  ex_waddr, mem_waddr, wb_waddr, iss_rd;
    logic [31:0] ex_wdata, mem_wdata, wb_wdata;
    wire         stall;

    logic [2:0]   w_re;
    logic [14:0]  w_raddr;
    wire  [191:0] w_rdata;
    logic         w_wb_we;
    logic [4:0]   w_wb_waddr;
    logic [63:0]  w_wb_wdata;
    wire          w_stall;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic [63:0] w_regs [32];

    regfile_sb #(.XLEN(32), .REG_NUM(32), .AW(5), .NRD(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .re_i(re), .raddr_i(raddr), .rdata_o(rdata),
        .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
        .mem_we_i(mem_we), .mem_waddr_i(mem_waddr), .mem_wdata_i(mem_wdata),
        .mem_is_load_i(mem_is_load),
        .wb_we_i(wb_we), .wb_waddr_i(wb_waddr), .wb_wdata_i(wb_wdata), .wb_is_load_i(wb_is_load),
        .iss_load_i(iss_load), .iss_rd_i(iss_rd), .flush_i(flush), .stallreq_o(stall)
    );

    regfile_sb #(.XLEN(64), .REG_NUM(32), .AW(5), .NRD(3)) dut_w (
        .clk(clk), .rst(rst), .rdy(rdy), .re_i(w_re), .raddr_i(w_raddr), .rdata_o(w_rdata),
        .ex_we_i(1'b0), .ex_waddr_i(5'd0), .ex_wdata_i(64'd0), .ex_is_load_i(1'b0),
        .mem_we_i(1'b0), .mem_waddr_i(5'd0), .mem_wdata_i(64'd0), .mem_is_load_i(1'b0),
        .wb_we_i(w_wb_we), .wb_waddr_i(w_wb_waddr), .wb_wdata_i(w_wb_wdata),
        .wb_is_load_i(1'b0), .iss_load_i(1'b0), .iss_rd_i(5'd0), .flush_i(1'b0),
        .stallreq_o(w_stall)
    );

    // Reference: what port k should see, taken straight from the read priority list.
    function automatic logic [31:0] m_data(input int k);
        logic [4:0] a;
        a = raddr[k*5 +: 5];
        if (rst || !re[k] || a == 5'd0) return 32'd0;
        if (ex_we && a == ex_waddr) return ex_is_load ? 32'd0 : ex_wdata;
        if (mem_we && a == mem_waddr) return mem_is_load ? 32'd0 : mem_wdata;
        if (wb_we && a == wb_waddr) return wb_wdata;
        if (m_busy[a]) return 32'd0;
        return m_regs[a];
    endfunction

    function automatic logic m_stall(input int k);
        logic [4:0] a;
        a = raddr[k*5 +: 5];
        if (rst || !re[k] || a == 5'd0) return 1'b0;
        if (ex_we && a == ex_waddr) return ex_is_load;
        if (mem_we && a == mem_waddr) return mem_is_load;
        if (wb_we && a == wb_waddr) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic idle();
        re = '0; raddr = '0;
        ex_we = 0; ex_waddr = 0; ex_wdata = 0; ex_is_load = 0;
        mem_we = 0; mem_waddr = 0; mem_wdata = 0; mem_is_load = 0;
        wb_we = 0; wb_waddr = 0; wb_wdata = 0; wb_is_load = 0;
        iss_load = 0; iss_rd = 0; flush = 0;
        w_re = '0; w_raddr = '0; w_wb_we = 0; w_wb_waddr = 0; w_wb_wdata = 0;
    endtask

    // Advance the model with the current inputs, then let the DUT take the same edge.
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_regs[i] = 0; w_regs[i] = 0; end
            m_busy = 0;
        end else if (rdy) begin
            if (wb_we && wb_waddr != 0) m_regs[wb_waddr] = wb_wdata;
            if (w_wb_we && w_wb_waddr != 0) w_regs[w_wb_waddr] = w_wb_wdata;
            if (flush) m_busy = 0;
            else begin
                if (wb_we && wb_is_load) m_busy[wb_waddr] = 1'b0;
                if (iss_load && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            end
            m_busy[0] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; rdy = 1;
        re = 2'b11; raddr = {5'd6, 5'd5};
        wb_we = 1; wb_waddr = 5; wb_wdata = 32'hCAFE_0005;
        ex_we = 1; ex_waddr = 6; ex_wdata = 32'h66; ex_is_load = 1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (rdata !== 64'd0 || stall !== 1'b0) begin
                failures++;
                $display("FAIL reset_force: rdata=%h stall=%b want 0/0", rdata, stall);
            end
            tick();
        end
        rst = 0;
        idle();
        for (int a = 1; a < 32; a++) begin
            re = 2'b11; raddr = {5'(32 - a), 5'(a)};
            #1;
            checks++;
            if (rdata !== 64'd0 || stall !== 1'b0) begin
                failures++;
                $display("FAIL reset_read x%0d: rdata=%h stall=%b want 0/0", a, rdata, stall);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_wb_bypass();
        idle();
        wb_we = 1; wb_waddr = 5; wb_wdata = 32'hDEADBEEF;
        re = 2'b01; raddr = {5'd0, 5'd5};
        #1;
        checks++;
        if (rdata[31:0] !== 32'hDEADBEEF || stall !== 1'b0) begin
            failures++;
            $display("FAIL wb_bypass: got %h stall=%b want deadbeef/0", rdata[31:0], stall);
        end
        tick();
        idle();
        re = 2'b10; raddr = {5'd5, 5'd0};
        #1;
        checks++;
        if (rdata[63:32] !== 32'hDEADBEEF || rdata[31:0] !== 32'd0) begin
            failures++;
            $display("FAIL wb_array: got %h want deadbeef_00000000", rdata);
        end
        tick();
    endtask

    task automatic test_forward_priority();
        idle();
        re = 2'b11; raddr = {5'd3, 5'd3};
        ex_we = 1; ex_waddr = 3; ex_wdata = 32'h11;
        mem_we = 1; mem_waddr = 3; mem_wdata = 32'h22;
        wb_we = 1; wb_waddr = 3; wb_wdata = 32'h33;
        #1;
        checks++;
        if (rdata !== {32'h11, 32'h11}) begin
            failures++;
            $display("FAIL fwd_ex: got %h want 11 on both ports", rdata);
        end
        ex_we = 0;
        #1;
        checks++;
        if (rdata[31:0] !== 32'h22) begin
            failures++;
            $display("FAIL fwd_mem: got %h want 22", rdata[31:0]);
        end
        mem_we = 0;
        #1;
        checks++;
        if (rdata[31:0] !== 32'h33 || stall !== 1'b0) begin
            failures++;
            $display("FAIL fwd_wb: got %h stall=%b want 33/0", rdata[31:0], stall);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        ex_we = 1; ex_waddr = 7; ex_wdata = 32'h77; ex_is_load = 1;
        re = 2'b11; raddr = {5'd7, 5'd8};
        #1;
        checks++;
        if (stall !== 1'b1 || rdata[63:32] !== 32'd0 || rdata[31:0] !== m_regs[8]) begin
            failures++;
            $display("FAIL ex_load_use: stall=%b rdata=%h want 1, p1=0, p0=%h",
                     stall, rdata, m_regs[8]);
        end
        idle();
        mem_we = 1; mem_waddr = 7; mem_wdata = 32'h78; mem_is_load = 1;
        re = 2'b01; raddr = {5'd0, 5'd7};
        #1;
        checks++;
        if (stall !== 1'b1 || rdata[31:0] !== 32'd0) begin
            failures++;
            $display("FAIL mem_load_use: stall=%b data=%h want 1/0", stall, rdata[31:0]);
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        idle();
        iss_load = 1; iss_rd = 9;
        tick();
        idle();
        re = 2'b01; raddr = {5'd0, 5'd9};
        #1;
        checks++;
        if (stall !== 1'b1 || rdata[31:0] !== 32'd0) begin
            failures++;
            $display("FAIL busy_stall: stall=%b data=%h want 1/0", stall, rdata[31:0]);
        end
        wb_we = 1; wb_waddr = 9; wb_wdata = 32'h55; wb_is_load = 1;
        #1;
        checks++;
        if (stall !== 1'b0 || rdata[31:0] !== 32'h55) begin
            failures++;
            $display("FAIL busy_wb_bypass: stall=%b data=%h want 0/55", stall, rdata[31:0]);
        end
        tick();
        idle();
        re = 2'b01; raddr = {5'd0, 5'd9};
        #1;
        checks++;
        if (stall !== 1'b0 || rdata[31:0] !== 32'h55) begin
            failures++;
            $display("FAIL busy_cleared: stall=%b data=%h want 0/55", stall, rdata[31:0]);
        end
        tick();
    endtask

    task automatic test_set_clear_flush();
        idle();
        iss_load = 1; iss_rd = 4;
        tick();
        idle();
        wb_we = 1; wb_waddr = 4; wb_wdata = 32'h44; wb_is_load = 1;
        iss_load = 1; iss_rd = 4;
        tick();
        idle();
        re = 2'b10; raddr = {5'd4, 5'd0};
        #1;
        checks++;
        if (stall !== 1'b1 || rdata[63:32] !== 32'd0) begin
            failures++;
            $display("FAIL set_over_clear: stall=%b data=%h want 1/0", stall, rdata[63:32]);
        end
        flush = 1; iss_load = 1; iss_rd = 10;
        tick();
        idle();
        re = 2'b11; raddr = {5'd4, 5'd10};
        #1;
        checks++;
        if (stall !== 1'b0 || rdata !== {32'h44, 32'd0}) begin
            failures++;
            $display("FAIL flush_clear: stall=%b rdata=%h want 0/00000044_00000000",
                     stall, rdata);
        end
        idle();
        rdy = 0;
        iss_load = 1; iss_rd = 12;
        wb_we = 1; wb_waddr = 12; wb_wdata = 32'h1212;
        tick();
        rdy = 1;
        idle();
        re = 2'b01; raddr = {5'd0, 5'd12};
        #1;
        checks++;
        if (stall !== 1'b0 || rdata[31:0] !== 32'd0) begin
            failures++;
            $display("FAIL rdy_freeze: stall=%b data=%h want 0/0", stall, rdata[31:0]);
        end
        tick();
    endtask

    task automatic test_random();
        rdy = 1;
        for (int n = 0; n < 400; n++) begin
            re = 2'($urandom);
            raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            ex_we = 1'($urandom_range(0, 3) == 0); ex_waddr = 5'($urandom_range(0, 7));
            ex_wdata = $urandom; ex_is_load = 1'($urandom);
            mem_we = 1'($urandom_range(0, 3) == 0); mem_waddr = 5'($urandom_range(0, 7));
            mem_wdata = $urandom; mem_is_load = 1'($urandom);
            wb_we = 1'($urandom); wb_waddr = 5'($urandom_range(0, 7));
            wb_wdata = $urandom; wb_is_load = 1'($urandom);
            iss_load = 1'($urandom_range(0, 2) == 0); iss_rd = 5'($urandom_range(0, 7));
            flush = 1'($urandom_range(0, 15) == 0);
            rdy = 1'($urandom_range(0, 7) != 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rdata[k*32 +: 32] !== m_data(k)) begin
                    failures++;
                    $display("FAIL rand_data cyc%0d port%0d: got %h want %h",
                             n, k, rdata[k*32 +: 32], m_data(k));
                end
            end
            checks++;
            if (stall !== (m_stall(0) | m_stall(1))) begin
                failures++;
                $display("FAIL rand_stall cyc%0d: got %b want %b", n, stall,
                         m_stall(0) | m_stall(1));
            end
            tick();
        end
        rdy = 1;
        idle();
    endtask

    task automatic test_wide();
        logic [63:0] vals [3];
        vals[0] = 64'h0123_4567_89AB_CDEF;
        vals[1] = 64'hFEDC_BA98_7654_3210;
        vals[2] = 64'hA5A5_5A5A_DEAD_BEEF;
        idle();
        rdy = 1;
        for (int i = 0; i < 3; i++) begin
            w_wb_we = 1; w_wb_waddr = 5'(i + 1); w_wb_wdata = vals[i];
            tick();
        end
        idle();
        w_re = 3'b111; w_raddr = {5'd1, 5'd3, 5'd2};
        #1;
        checks++;
        if (w_rdata !== {vals[0], vals[2], vals[1]} || w_stall !== 1'b0) begin
            failures++;
            $display("FAIL wide_read: got %h stall=%b", w_rdata, w_stall);
        end
        w_re = 3'b000;
        rdy = 0;
        w_wb_we = 1; w_wb_waddr = 1; w_wb_wdata = 64'h1111_2222_3333_4444;
        tick();
        rdy = 1;
        idle();
        w_re = 3'b001; w_raddr = {5'd0, 5'd0, 5'd1};
        #1;
        checks++;
        if (w_rdata[63:0] !== vals[0] || w_rdata[191:64] !== 128'd0) begin
            failures++;
            $display("FAIL wide_rdy_block: got %h want %h", w_rdata[63:0], vals[0]);
        end
        tick();
    endtask

    initial begin
        idle();
        rst = 1; rdy = 1;
        test_reset();
        test_wb_bypass();
        test_forward_priority();
        test_load_use();
        test_scoreboard();
        test_set_clear_flush();
        test_random();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
